// File: rtl/codec_cfg_pkg.sv
// Shared types and constants for the codec configuration sequencer:
// FSM state encoding, codec device address and the register-write table.
`default_nettype none

package codec_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_GAP       = 3'd3,
    ST_DONE      = 3'd4,
    ST_ERROR     = 3'd5
  } cfg_state_t;

  localparam logic [7:0]  CODEC_DEV_ADDR = 8'h34;

  localparam logic [15:0] REG_RESET    = 16'h1E00;
  localparam logic [15:0] REG_PATH     = 16'h0A04;
  localparam logic [15:0] REG_DAC      = 16'h0810;
  localparam logic [15:0] REG_POWER    = 16'h0C00;
  localparam logic [15:0] REG_FORMAT   = 16'h0E01;
  localparam logic [15:0] REG_SAMPLING = 16'h1002;
  localparam logic [15:0] REG_ACTIVATE = 16'h1201;

endpackage

`default_nettype wire

// File: rtl/codec_reg_rom.sv
// Combinational codec register table: 4-bit index to 16-bit register word.
// Indices past the populated table return zero.
`default_nettype none

module codec_reg_rom
  import codec_cfg_pkg::*;
(
  input  logic [3:0]  index,
  output logic [15:0] word
);

  // Activate has to remain the final entry so the codec only runs once configured.
  always_comb begin
    word = 16'h0000;
    case (index)
      4'd0:    word = REG_RESET;
      4'd1:    word = REG_PATH;
      4'd2:    word = REG_DAC;
      4'd3:    word = REG_POWER;
      4'd4:    word = REG_FORMAT;
      4'd5:    word = REG_SAMPLING;
      4'd6:    word = REG_ACTIVATE;
      default: word = 16'h0000;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/codec_cfg_sequencer.sv
// Walks the codec register table, issuing one 24-bit I2C write per entry with
// NACK retry, watchdog timeout, inter-transaction gap and done/error status.
`default_nettype none

module codec_cfg_sequencer
  import codec_cfg_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR       = CODEC_DEV_ADDR,
  parameter int         NUM_REGS       = 7,
  parameter int         MAX_RETRY      = 3,
  parameter int         GAP_CYCLES     = 2500,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter bit         AUTO_START     = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        tx_start,
  output logic [23:0] tx_data,
  input  logic        tx_done,
  input  logic        tx_ack,
  output logic        busy,
  output logic        cfg_done,
  output logic        cfg_error,
  output logic [3:0]  cur_index
);

  localparam int RETRY_W = (MAX_RETRY > 3) ? $clog2(MAX_RETRY + 1) : 2;
  localparam int GAP_W   = $clog2(GAP_CYCLES + 1);

  localparam logic [19:0]        TIMER_LAST  = 20'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST    = GAP_W'(GAP_CYCLES - 1);
  localparam logic [3:0]         LAST_INDEX  = 4'(NUM_REGS - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

  cfg_state_t         state, state_next;
  logic [3:0]         index, index_next;
  logic [RETRY_W-1:0] retry, retry_next;
  logic [19:0]        timer, timer_next;
  logic [GAP_W-1:0]   gap_cnt, gap_next;
  logic [15:0]        rom_word;
  logic               attempt_ok, attempt_bad;

  // ROM is addressed with the next index so TX_DATA is loaded as ISSUE is entered.
  codec_reg_rom u_rom (
    .index (index_next),
    .word  (rom_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      index   <= '0;
      retry   <= '0;
      timer   <= '0;
      gap_cnt <= '0;
      tx_data <= '0;
    end else begin
      state   <= state_next;
      index   <= index_next;
      retry   <= retry_next;
      timer   <= timer_next;
      gap_cnt <= gap_next;
      if (state_next == ST_ISSUE) begin
        tx_data <= {DEV_ADDR, rom_word};
      end
    end
  end

  always_comb begin
    state_next  = state;
    index_next  = index;
    retry_next  = retry;
    timer_next  = timer;
    gap_next    = gap_cnt;
    attempt_ok  = 1'b0;
    attempt_bad = 1'b0;

    case (state)
      ST_IDLE: begin
        if (AUTO_START || start) begin
          state_next = ST_ISSUE;
          index_next = '0;
          retry_next = '0;
        end
      end
      ST_ISSUE: begin
        state_next = ST_WAIT_DONE;
        timer_next = '0;
      end
      ST_WAIT_DONE: begin
        if (timer != '1) begin
          timer_next = timer + 20'd1;
        end
        // A completion on the expiry cycle takes precedence over the watchdog.
        attempt_ok  = tx_done && tx_ack;
        attempt_bad = tx_done ? !tx_ack : (timer == TIMER_LAST);
        if (attempt_ok) begin
          retry_next = '0;
          if (index == LAST_INDEX) begin
            state_next = ST_DONE;
          end else begin
            index_next = index + 4'd1;
            gap_next   = '0;
            state_next = ST_GAP;
          end
        end else if (attempt_bad) begin
          if (retry == RETRY_LIMIT) begin
            state_next = ST_ERROR;
          end else begin
            retry_next = retry + 1'b1;
            gap_next   = '0;
            state_next = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_next = ST_ISSUE;
        end else begin
          gap_next = gap_cnt + 1'b1;
        end
      end
      ST_DONE, ST_ERROR: begin
        if (start) begin
          index_next = '0;
          retry_next = '0;
          state_next = ST_ISSUE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign tx_start  = (state == ST_ISSUE);
  assign busy      = (state == ST_ISSUE) || (state == ST_WAIT_DONE) || (state == ST_GAP);
  assign cfg_done  = (state == ST_DONE);
  assign cfg_error = (state == ST_ERROR);
  assign cur_index = index;

endmodule

`default_nettype wire

// File: tb/tb_codec_cfg_sequencer.sv
// Scoreboard bench for codec_cfg_sequencer with a behavioural I2C controller
// model whose ACK, NACK, hang and latency behaviour is set per scenario.
`default_nettype none

module tb_codec_cfg_sequencer;

  localparam int GAP = 4;
  localparam int TMO = 64;

  localparam logic [23:0] WORDS [7] = '{
    24'h341E00, 24'h340A04, 24'h340810, 24'h340C00,
    24'h340E01, 24'h341002, 24'h341201
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        tx_done = 1'b0;
  logic        tx_ack = 1'b0;
  logic        tx_start, busy, cfg_done, cfg_error;
  logic [23:0] tx_data;
  logic [3:0]  cur_index;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [23:0] exp_q [$];
  logic [23:0] exp_word;
  int          starts [$];
  int          last_done = 0;
  bit          done_since = 1'b0;

  int nack_entry = -1, nack_left = 0;
  int hang_entry = -1, hang_left = 0;
  int slow_entry = -1, slow_left = 0, slow_lat = 10;
  int m_lat;
  bit m_ack, m_abort;

  codec_cfg_sequencer #(
    .DEV_ADDR       (8'h34),
    .NUM_REGS       (7),
    .MAX_RETRY      (3),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO),
    .AUTO_START     (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_done   (tx_done),
    .tx_ack    (tx_ack),
    .busy      (busy),
    .cfg_done  (cfg_done),
    .cfg_error (cfg_error),
    .cur_index (cur_index)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // I2C controller model: answers each TX_START after m_lat cycles unless told to hang.
  initial forever begin
    @(negedge clk);
    if (rst_n && tx_start) begin
      m_lat = 10;
      m_ack = 1'b1;
      if (int'(cur_index) == hang_entry && hang_left > 0) begin
        hang_left--;
      end else begin
        if (int'(cur_index) == nack_entry && nack_left > 0) begin
          nack_left--;
          m_ack = 1'b0;
        end
        if (int'(cur_index) == slow_entry && slow_left > 0) begin
          slow_left--;
          m_lat = slow_lat;
        end
        m_abort = 1'b0;
        for (int i = 0; i < m_lat; i++) begin
          @(negedge clk);
          if (!rst_n) begin
            m_abort = 1'b1;
            break;
          end
        end
        if (!m_abort) begin
          tx_ack  = m_ack;
          tx_done = 1'b1;
          @(negedge clk);
          tx_done = 1'b0;
          tx_ack  = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every TX_START and checks gap timing after TX_DONE.
  initial forever begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      done_since = 1'b0;
    end else begin
      if (tx_done) begin
        done_since = 1'b1;
        last_done  = cyc;
      end
      if (cfg_done || cfg_error) done_since = 1'b0;
      if (tx_start) begin
        starts.push_back(cyc);
        chk("tx_start_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          exp_word = exp_q.pop_front();
          chk("tx_data", {8'h0, tx_data}, {8'h0, exp_word});
        end
        if (done_since) chk("start_after_done_gap", 32'(cyc - last_done), 32'(GAP + 1));
        done_since = 1'b0;
      end
    end
  end

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_q.push_back(WORDS[i]);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_status"}, {26'h0, tx_start, busy, cfg_done, cfg_error, 2'b00} | {28'h0, cur_index}, 32'h0);
    chk({name, "_tx_data"}, {8'h0, tx_data}, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    nack_entry = -1; nack_left = 0;
    hang_entry = -1; hang_left = 0;
    slow_entry = -1; slow_left = 0;
    exp_q.delete();
    starts.delete();
  endtask

  task automatic wait_end(input string name, input int budget);
    int n;
    n = 0;
    while (!(cfg_done || cfg_error) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_finished_in_budget"}, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_issue(input string name, input logic [3:0] idx);
    int n;
    n = 0;
    while (!(tx_start && cur_index == idx) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_issue_seen"}, 32'(n < 500), 32'd1);
  endtask

  initial begin
    // All entries ACKed; first TX_START on the first edge after reset release.
    do_reset();
    push_range(0, 6);
    rst_n = 1'b1;
    @(negedge clk);
    chk("s1_autostart", 32'(tx_start), 32'd1);
    wait_end("s1", 2000);
    chk("s1_done", 32'(cfg_done), 32'd1);
    chk("s1_error", 32'(cfg_error), 32'd0);
    chk("s1_busy", 32'(busy), 32'd0);
    chk("s1_index", 32'(cur_index), 32'd6);
    chk("s1_queue_empty", 32'(exp_q.size()), 32'd0);

    // Entry 3 NACKed twice, then ACKed.
    do_reset();
    nack_entry = 3; nack_left = 2;
    push_range(0, 3); push_range(3, 3); push_range(3, 6);
    rst_n = 1'b1;
    wait_end("s2", 2000);
    chk("s2_done", 32'(cfg_done), 32'd1);
    chk("s2_attempts", 32'(starts.size()), 32'd9);
    chk("s2_queue_empty", 32'(exp_q.size()), 32'd0);

    // Entry 2 always NACKed: four attempts then ERROR.
    do_reset();
    nack_entry = 2; nack_left = 100;
    push_range(0, 2); push_range(2, 2); push_range(2, 2); push_range(2, 2);
    rst_n = 1'b1;
    wait_end("s3", 2000);
    chk("s3_error", 32'(cfg_error), 32'd1);
    chk("s3_done", 32'(cfg_done), 32'd0);
    chk("s3_index", 32'(cur_index), 32'd2);
    chk("s3_busy", 32'(busy), 32'd0);
    repeat (50) @(negedge clk);
    chk("s3_attempts", 32'(starts.size()), 32'd6);
    chk("s3_queue_empty", 32'(exp_q.size()), 32'd0);

    // Entry 0 never answered: each attempt times out after 64 WAIT cycles.
    do_reset();
    hang_entry = 0; hang_left = 100;
    for (int i = 0; i < 4; i++) push_range(0, 0);
    rst_n = 1'b1;
    wait_end("s4a", 2000);
    chk("s4a_error", 32'(cfg_error), 32'd1);
    chk("s4a_index", 32'(cur_index), 32'd0);
    chk("s4a_attempts", 32'(starts.size()), 32'd4);
    for (int i = 0; i < 3 && i + 1 < starts.size(); i++)
      chk("s4a_timeout_period", 32'(starts[i+1] - starts[i]), 32'(TMO + GAP + 1));
    chk("s4a_queue_empty", 32'(exp_q.size()), 32'd0);

    // ACK arriving exactly on the expiry cycle passes the entry.
    do_reset();
    slow_entry = 0; slow_left = 1; slow_lat = TMO;
    push_range(0, 6);
    rst_n = 1'b1;
    wait_end("s4b", 2000);
    chk("s4b_done", 32'(cfg_done), 32'd1);
    chk("s4b_expiry_ack_period", 32'(starts.size() > 1 ? starts[1] - starts[0] : 0), 32'(TMO + GAP + 1));
    chk("s4b_queue_empty", 32'(exp_q.size()), 32'd0);

    // START while busy is ignored; START in DONE reruns from entry 0.
    do_reset();
    push_range(0, 6);
    rst_n = 1'b1;
    wait_issue("s5", 4'd1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end("s5", 2000);
    chk("s5_done", 32'(cfg_done), 32'd1);
    chk("s5_attempts", 32'(starts.size()), 32'd7);
    chk("s5_queue_empty", 32'(exp_q.size()), 32'd0);
    push_range(0, 6);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("s5_restart_tx_start", 32'(tx_start), 32'd1);
    chk("s5_restart_data", {8'h0, tx_data}, 32'h00341E00);
    chk("s5_restart_index", 32'(cur_index), 32'd0);
    wait_end("s5r", 2000);
    chk("s5r_done", 32'(cfg_done), 32'd1);
    chk("s5r_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-WAIT_DONE of entry 4 clears outputs at once; sequence restarts.
    do_reset();
    push_range(0, 4);
    rst_n = 1'b1;
    wait_issue("s6", 4'd4);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("s6_async_reset");
    chk("s6_pre_reset_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    push_range(0, 6);
    rst_n = 1'b1;
    wait_end("s6", 2000);
    chk("s6_done", 32'(cfg_done), 32'd1);
    chk("s6_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL global_timeout: simulation exceeded cycle budget");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "global timeout");
  end

endmodule

`default_nettype wire
